// File: rtl/pll_freq_meter_pkg.sv
// Shared types for the PLL frequency meter: FSM state encoding and gate counter sizing.
// No logic; imported by the meter top.
package pll_freq_meter_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_GATE  = 2'd2,
    ST_LATCH = 2'd3
  } state_e;

  // Gate counter runs 0..GATE_CYCLES-1, so clog2 of the window length suffices.
  function automatic int gate_cnt_w(input int gate_cycles);
    return (gate_cycles < 2) ? 1 : $clog2(gate_cycles);
  endfunction

endpackage

// File: rtl/sync_rise_det.sv
// SYNC_STAGES flop synchronizer followed by a registered rising-edge detector.
// Input edge to output pulse: SYNC_STAGES+1 clk cycles; no backpressure.
module sync_rise_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      last  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], d};
      last  <= sync[SYNC_STAGES-1];
      pulse <= sync[SYNC_STAGES-1] & ~last;
    end
  end

endmodule

// File: rtl/pll_freq_meter.sv
// Counts sig_in rising edges over a GATE_CYCLES window, one result per GATE_CYCLES+2 cycles.
// No backpressure; optional in_range flag under PLL_FREQ_METER_RANGE_CHECK_EN.
module pll_freq_meter
  import pll_freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 27000000,
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2,
  parameter int LO_LIMIT    = 0,
  parameter int HI_LIMIT    = (1 << CNT_W) - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             overflow
`ifdef PLL_FREQ_METER_RANGE_CHECK_EN
  ,
  output logic             in_range
`endif
);

  localparam int               GW        = gate_cnt_w(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e           state;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic             win_ovf;
  logic             edge_pulse;
  logic             edge_sat;
  logic [CNT_W-1:0] next_cnt;
  logic             next_ovf;

  sync_rise_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_rise_det (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sig_in),
    .pulse (edge_pulse)
  );

  // Counter value including this cycle's edge, so the final gate cycle is not lost.
  assign edge_sat = (edge_cnt == CNT_MAX);
  assign next_cnt = (edge_pulse && !edge_sat) ? edge_cnt + CNT_W'(1) : edge_cnt;
  assign next_ovf = win_ovf | (edge_pulse & edge_sat);

`ifdef PLL_FREQ_METER_RANGE_CHECK_EN
  logic range_ok;
  assign range_ok = (int'(next_cnt) >= LO_LIMIT) && (int'(next_cnt) <= HI_LIMIT) && !next_ovf;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      gate_cnt    <= '0;
      edge_cnt    <= '0;
      win_ovf     <= 1'b0;
      count       <= '0;
      count_valid <= 1'b0;
      overflow    <= 1'b0;
`ifdef PLL_FREQ_METER_RANGE_CHECK_EN
      in_range    <= 1'b0;
`endif
    end else begin
      count_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en) state <= ST_ARM;
        end
        ST_ARM: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          win_ovf  <= 1'b0;
          state    <= en ? ST_GATE : ST_IDLE;
        end
        ST_GATE: begin
          // Dropping en aborts the window even on its last cycle; results hold.
          if (!en) begin
            state <= ST_IDLE;
          end else begin
            edge_cnt <= next_cnt;
            win_ovf  <= next_ovf;
            if (gate_cnt == GATE_LAST) begin
              state       <= ST_LATCH;
              count       <= next_cnt;
              overflow    <= next_ovf;
              count_valid <= 1'b1;
`ifdef PLL_FREQ_METER_RANGE_CHECK_EN
              in_range    <= range_ok;
`endif
            end else begin
              gate_cnt <= gate_cnt + GW'(1);
            end
          end
        end
        ST_LATCH: begin
          state <= en ? ST_ARM : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_freq_meter.sv
// Scoreboard bench for pll_freq_meter: expected windows are queued as stimulus is set
// and popped on each count_valid; a second CNT_W=3 instance covers saturation.
module tb_pll_freq_meter;
  import pll_freq_meter_pkg::*;

  localparam int GATE = 100;
  localparam int PER  = GATE + 2;

  typedef struct {
    int cnt;
    bit ovf;
    bit chk;
    int gap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, en, sig;
  logic [7:0] count;
  logic       count_valid, overflow;
  logic       rst2_n, en2, sig2;
  logic [2:0] count2;
  logic       count_valid2, overflow2;
`ifdef PLL_FREQ_METER_RANGE_CHECK_EN
  logic       in_range, in_range2;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   ref_cyc  = 0;
  int   per      = 0;
  int   hi       = 0;
  int   ph       = 0;
  bit   cval     = 1'b0;
  bit   ovf_done = 1'b0;
  exp_t sb[$];

  pll_freq_meter #(
    .GATE_CYCLES (GATE), .CNT_W (8), .SYNC_STAGES (2), .LO_LIMIT (9), .HI_LIMIT (11)
  ) dut (
    .clk (clk), .rst_n (rst_n), .en (en), .sig_in (sig),
    .count (count), .count_valid (count_valid), .overflow (overflow)
`ifdef PLL_FREQ_METER_RANGE_CHECK_EN
    , .in_range (in_range)
`endif
  );

  pll_freq_meter #(
    .GATE_CYCLES (GATE), .CNT_W (3), .SYNC_STAGES (2)
  ) dut_ovf (
    .clk (clk), .rst_n (rst2_n), .en (en2), .sig_in (sig2),
    .count (count2), .count_valid (count_valid2), .overflow (overflow2)
`ifdef PLL_FREQ_METER_RANGE_CHECK_EN
    , .in_range (in_range2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int cnt, input bit chk, input int gap);
    exp_t e;
    e.cnt = cnt;
    e.ovf = 1'b0;
    e.chk = chk;
    e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic wait_empty(input int budget);
    int t;
    t = 0;
    while (sb.size() != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("sb_drain_timeout", sb.size(), 0);
    @(negedge clk);
  endtask

  task automatic set_sig(input int p, input int h, input bit c);
    per  = p;
    hi   = h;
    cval = c;
    ph   = 0;
  endtask

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Stimulus for the main instance, changed on the falling edge.
  initial begin
    sig = 1'b0;
    forever begin
      @(negedge clk);
      if (per == 0) begin
        sig = cval;
      end else begin
        ph  = (ph + 1) % per;
        sig = (ph < hi);
      end
    end
  end

  // Scoreboard monitor.
  initial forever begin
    @(negedge clk);
    if (count_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk) begin
          check("count", count, e.cnt);
          check("overflow", overflow, e.ovf);
`ifdef PLL_FREQ_METER_RANGE_CHECK_EN
          check("in_range", in_range, (e.cnt >= 9 && e.cnt <= 11 && !e.ovf) ? 1 : 0);
`endif
        end
        if (e.gap != 0) check("valid_gap", cyc - ref_cyc, e.gap);
      end
      ref_cyc = cyc;
    end
  end

  // Saturation instance: period 4 gives 25 edges per window into a 3-bit counter.
  initial begin
    int ph2;
    ph2  = 0;
    sig2 = 1'b0;
    forever begin
      @(negedge clk);
      ph2  = (ph2 + 1) % 4;
      sig2 = (ph2 < 2);
    end
  end

  initial begin
    rst2_n = 1'b0;
    en2    = 1'b0;
    repeat (2) @(negedge clk);
    rst2_n = 1'b1;
    en2    = 1'b1;
    for (int k = 0; k < 2; k++) begin
      int t;
      t = 0;
      while (!count_valid2 && t < 2 * PER) begin
        @(negedge clk);
        t++;
      end
      check("ovf_valid_timeout", (t < 2 * PER) ? 1 : 0, 1);
      check("ovf_count", count2, 7);
      check("ovf_flag", overflow2, 1);
`ifdef PLL_FREQ_METER_RANGE_CHECK_EN
      check("ovf_in_range", in_range2, 0);
`endif
      @(negedge clk);
    end
    ovf_done = 1'b1;
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    set_sig(0, 0, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_valid", count_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_state", 32'(dut.state), 32'(ST_IDLE));
`ifdef PLL_FREQ_METER_RANGE_CHECK_EN
    check("rst_in_range", in_range, 0);
`endif

    // Period 10, enabled straight out of reset.
    set_sig(10, 5, 1'b0);
    rst_n   = 1'b1;
    en      = 1'b1;
    ref_cyc = cyc;
    repeat (3) push(10, 1'b1, PER);
    wait_empty(4 * PER);

    // Abort around GATE cycle 50: nothing publishes, results hold.
    repeat (52) @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_state", 32'(dut.state), 32'(ST_IDLE));
    check("abort_count_hold", count, 10);
    repeat (150) @(negedge clk);
    check("abort_count_hold2", count, 10);
    check("abort_no_valid", sb.size(), 0);
    en      = 1'b1;
    ref_cyc = cyc;
    repeat (2) push(10, 1'b1, PER);
    wait_empty(3 * PER);

    // Constant high: only the transitional window may see an edge.
    set_sig(0, 0, 1'b1);
    push(0, 1'b0, PER);
    repeat (2) push(0, 1'b1, PER);
    wait_empty(4 * PER);

    // Period 5: 20 edges, outside the 9..11 range.
    set_sig(5, 3, 1'b0);
    push(0, 1'b0, PER);
    repeat (2) push(20, 1'b1, PER);
    wait_empty(4 * PER);

    set_sig(10, 5, 1'b0);
    push(0, 1'b0, PER);
    push(10, 1'b1, PER);
    wait_empty(3 * PER);

    // Asynchronous reset mid-window.
    repeat (50) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_valid", count_valid, 0);
    check("arst_overflow", overflow, 0);
    check("arst_state", 32'(dut.state), 32'(ST_IDLE));
`ifdef PLL_FREQ_METER_RANGE_CHECK_EN
    check("arst_in_range", in_range, 0);
`endif
    @(negedge clk);
    rst_n   = 1'b1;
    ref_cyc = cyc;
    push(0, 1'b0, PER);
    push(10, 1'b1, PER);
    wait_empty(3 * PER);

    begin
      int t;
      t = 0;
      while (!ovf_done && t < 4 * PER) begin
        @(negedge clk);
        t++;
      end
      check("ovf_done_timeout", ovf_done, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
